// File: rtl/activation_controller.sv
// ---------------------------------------------------------------------------
// activation_controller
// Sequences the shared activation datapath over one tile of systolic-array
// results. For each row it reads the accumulator buffer, waits out the read
// latency, captures the activation-unit output, then writes the row to the
// output buffer. Only one row is ever in flight.
//
// Handshake: a write to the output buffer completes in a cycle where wr_en_o
// and wr_ready_i are both high. While wr_ready_i is low, wr_en_o and
// wr_addr_o hold steady, and the capture register is left untouched.
// ---------------------------------------------------------------------------
module activation_controller #(
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [1:0]            func_i,
   input  logic [ADDR_WIDTH:0]   num_rows_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  act_en_o,
   output logic [1:0]            act_sel_o,
   output logic                  cap_en_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   input  logic                  wr_ready_i,
   output logic [2:0]            state_dbg_o
);

   // The wait counter holds values up to RD_LATENCY-1.
   localparam int WC_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_ACT   = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic [WC_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]            func_q, func_d;
   logic [ADDR_WIDTH:0]   num_rows_q, num_rows_d;

   logic                  start_ok;
   logic                  last_row;
   logic [ADDR_WIDTH:0]   last_idx;

   // A start is only honoured when idle, and abort overrides it.
   assign start_ok = (state_q == S_IDLE) && start_i && !abort_i;

   // Index of the final row; only meaningful while a non-empty tile runs.
   assign last_idx = num_rows_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
   // row_cnt is zero-extended so a full 2**ADDR_WIDTH tile ends without wrap.
   assign last_row = ({1'b0, row_cnt_q} == last_idx);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort returns to IDLE from anywhere.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = (num_rows_i == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = S_ACT;
            end
         end
         S_ACT: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (wr_ready_i) begin
               state_d = last_row ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort_i) begin
         state_d = S_IDLE;
      end
   end

   // Tile configuration and row/wait counters.
   always_comb begin
      row_cnt_d  = row_cnt_q;
      wait_cnt_d = wait_cnt_q;
      func_d     = func_q;
      num_rows_d = num_rows_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               func_d     = func_i;
               num_rows_d = num_rows_i;
               row_cnt_d  = '0;
            end
         end
         S_READ: begin
            wait_cnt_d = WC_W'(RD_LATENCY - 1);
         end
         S_WAIT: begin
            if (wait_cnt_q != '0) begin
               wait_cnt_d = wait_cnt_q - {{(WC_W-1){1'b0}}, 1'b1};
            end
         end
         S_WRITE: begin
            // Advance only when the write is accepted and rows remain.
            if (wr_ready_i && !last_row && !abort_i) begin
               row_cnt_d = row_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_cnt_q  <= '0;
         wait_cnt_q <= '0;
         func_q     <= '0;
         num_rows_q <= '0;
      end else begin
         row_cnt_q  <= row_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         func_q     <= func_d;
         num_rows_q <= num_rows_d;
      end
   end

   // Output decode from registered state only; no input-to-output paths.
   always_comb begin
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE);
      rd_en_o     = (state_q == S_READ);
      rd_addr_o   = row_cnt_q;
      cap_en_o    = (state_q == S_ACT);
      act_en_o    = (state_q == S_ACT) && (func_q != 2'd0);
      act_sel_o   = (state_q != S_IDLE) ? func_q : 2'd0;
      wr_en_o     = (state_q == S_WRITE);
      wr_addr_o   = row_cnt_q;
      state_dbg_o = state_q;
   end

endmodule

// File: doc/activation_controller.md
Name: activation_controller

Overview:
- Sequences the shared activation datapath (bypass / ReLU / Sigmoid / Tanh) over one tile of systolic-array results.
- Reads rows from the accumulator buffer, drives enable/select of the combinational activation unit and its output capture register, then writes each result row to the output buffer.
- Honours output-buffer backpressure; one row in flight at a time.
- Sits between the layer scheduler (start/done) and the accumulator buffer, activation unit and output buffer.

Parameters:
- ADDR_WIDTH, 8, row address width; max tile = 2**ADDR_WIDTH rows.
- RD_LATENCY, 1, accumulator-buffer read latency in cycles; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a tile; ignored unless idle.
- abort  input  1  synchronous abort; returns to IDLE without done.
- func  input  2  0 bypass, 1 ReLU, 2 Sigmoid, 3 Tanh; sampled on accepted start.
- num_rows  input  ADDR_WIDTH+1  rows in tile, 0..2**ADDR_WIDTH; sampled on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last row is written.
- rd_en  output  1  accumulator-buffer read strobe.
- rd_addr  output  ADDR_WIDTH  read row address.
- act_en  output  1  activation-unit enable; low for bypass.
- act_sel  output  2  latched func driven to the activation mux.
- cap_en  output  1  load activation output register this cycle.
- wr_en  output  1  output-buffer write request.
- wr_addr  output  ADDR_WIDTH  write row address.
- wr_ready  input  1  output buffer accepts the write this cycle.

Behaviour:
- Reset: state IDLE; busy, done, rd_en, act_en, cap_en, wr_en = 0; act_sel, rd_addr, wr_addr, row_cnt, wait_cnt, latched func/num_rows = 0.
- States: IDLE, READ, WAIT, ACT, WRITE, DONE. All outputs are registered or decoded from state only; no combinational input-to-output path except none.
- IDLE: start=1 latches func and num_rows and clears row_cnt.
  - num_rows==0 -> DONE.
  - Otherwise -> READ.
- READ (1 cycle): rd_en=1, rd_addr=row_cnt. Next state WAIT; wait_cnt loaded with RD_LATENCY-1.
- WAIT: holds until wait_cnt==0, decrementing each cycle (exactly RD_LATENCY cycles), then -> ACT.
- ACT (1 cycle):
  - cap_en=1.
  - act_en = (func != 0).
  - act_sel = latched func. act_sel holds the latched value in all non-IDLE states.
  - Next state WRITE.
- WRITE: wr_en=1, wr_addr=row_cnt.
  - wr_ready=0: stay; wr_en, wr_addr and the capture register stay stable.
  - wr_ready=1 and row_cnt == num_rows-1: -> DONE.
  - wr_ready=1 otherwise: row_cnt+1, -> READ.
- DONE (1 cycle): done=1, then -> IDLE.
- Throughput: RD_LATENCY+3 cycles per row with wr_ready held high. Total tile time from start to done = N*(RD_LATENCY+3)+1 cycles.
- num_rows = 2**ADDR_WIDTH: row_cnt reaches 2**ADDR_WIDTH-1 and the tile ends there. The address must not wrap before done.
- start while busy: ignored; latched config unchanged.
- abort, any non-IDLE state: next state IDLE.
  - rd_en, act_en, cap_en, wr_en deassert the next cycle; no done.
  - A pending write is dropped.
  - abort has priority over every transition, including DONE.
- abort and start in the same cycle while IDLE: abort wins; start is ignored.
- rst mid-tile: immediate return to reset values; no done.

Test Plan:
- RD_LATENCY=1, func=3, num_rows=2, wr_ready=1, start @cycle0:
  - rd_en @1,5; act_en=1 with cap_en @3,7; wr_en @4 addr0, @8 addr1.
  - done @9; busy high cycles 1-9.
- func=0, num_rows=1: act_en stays 0 throughout; cap_en=1 @3; wr_en @4; done @5.
- num_rows=0, start: busy @1 only, done @1, no rd_en/wr_en ever.
- num_rows=3, wr_ready held low 4 cycles on row 1: wr_en/wr_addr=1 held 5 cycles; no second rd_en until accepted; done delayed exactly 4 cycles vs. baseline.
- abort asserted during WAIT of row 2 of 4: IDLE next cycle, all strobes 0, no done; a new start then runs a clean tile from addr0 with new func.
- ADDR_WIDTH=2, num_rows=4, RD_LATENCY=3: rows 0..3 written in order, 6 cycles/row, done @25; start pulsed mid-tile is ignored; rst asserted mid-WRITE clears all outputs asynchronously.
